// File: rtl/sd_channel_arbiter_pkg.sv
// Shared types and constants for the MiSTer block-device channel arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam int N_REQ_DEF = 3;
  localparam int LBA_W_DEF = 32;

  localparam int FDD1 = 0;
  localparam int HDD  = 1;
  localparam int FDD2 = 2;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_channel_arbiter_if.sv
// Requester-side and host-side signals of the shared block-device channel.
interface sd_channel_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int LBA_W = 32
);
  logic [N_REQ*LBA_W-1:0] req_lba;
  logic [N_REQ-1:0]       req_rd;
  logic [N_REQ-1:0]       req_wr;
  logic [N_REQ-1:0]       req_ack;
  logic [N_REQ*8-1:0]     req_buff_din;
  logic [N_REQ-1:0]       req_buff_wr;
  logic [LBA_W-1:0]       sd_lba;
  logic                   sd_rd;
  logic                   sd_wr;
  logic                   sd_ack;
  logic                   sd_buff_wr;
  logic [7:0]             sd_buff_din;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
           grant, busy, timeout_err
  );

  modport slave (
    output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
           grant, busy, timeout_err
  );
endinterface

// File: rtl/sd_channel_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Walk offsets from farthest to nearest so the nearest pending index wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (pend[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sd_channel_arbiter.sv
// Round-robin owner of the single host block-device channel (floppy 1, HDD, floppy 2).
module sd_channel_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int LBA_W          = LBA_W_DEF,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_channel_arbiter_if.master bus
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr, winner;
  logic             valid;
  logic [N_REQ-1:0] pend, grant_q;
  logic [LBA_W-1:0] lba_q, lba_sel;
  logic             rd_q, wr_q, te_q, ack_d;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       din_sel;

  assign pend = bus.req_rd | bus.req_wr;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (valid)
  );

  assign lba_sel = bus.req_lba[int'(winner)*LBA_W +: LBA_W];

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_q[i]) din_sel = din_sel | bus.req_buff_din[i*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      te_q    <= 1'b0;
      cnt     <= '0;
      ack_d   <= 1'b0;
    end else begin
      ack_d <= bus.sd_ack;
      te_q  <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          state   <= REQ;
          grant_q <= N_REQ'(1) << winner;
          lba_q   <= lba_sel;
          // A simultaneous write stays pending and is served on a later grant.
          rd_q    <= bus.req_rd[winner];
          wr_q    <= bus.req_wr[winner] & ~bus.req_rd[winner];
          rr_ptr  <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          cnt     <= '0;
        end
        REQ: begin
          if (~ack_d & bus.sd_ack) begin
            state <= XFER;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            te_q    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: if (ack_d & ~bus.sd_ack) state <= DONE;
        DONE: begin
          grant_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = {N_REQ{bus.sd_ack}} & grant_q;
  assign bus.req_buff_wr = {N_REQ{bus.sd_buff_wr & bus.sd_ack}} & grant_q;
  assign bus.sd_buff_din = din_sel;
  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = rd_q;
  assign bus.sd_wr       = wr_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = te_q;
endmodule

// File: tb/tb_sd_channel_arbiter.sv
// Directed bench for sd_channel_arbiter: routing, round-robin order, timeout and reset.
module tb_sd_channel_arbiter;
  import sd_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sd_channel_arbiter_if #(.N_REQ(3), .LBA_W(32)) bus ();

  sd_channel_arbiter #(.N_REQ(3), .LBA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int hits, stray;
    reset            = 1'b1;
    bus.req_lba      = '0;
    bus.req_rd       = '0;
    bus.req_wr       = '0;
    bus.req_buff_din = '0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_wr   = 1'b0;
    tick(2);
    chk("rst_grant", bus.grant, 3'b000);
    chk("rst_rd", bus.sd_rd, 1'b0);
    chk("rst_wr", bus.sd_wr, 1'b0);
    chk("rst_lba", bus.sd_lba, 32'h0);
    chk("rst_te", bus.timeout_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    tick(1);

    // Single read on the HDD slot
    bus.req_lba[HDD*32 +: 32] = 32'h1234;
    bus.req_rd = 3'b010;
    tick(1);
    chk("rd_grant", bus.grant, 3'b010);
    chk("rd_strobe", bus.sd_rd, 1'b1);
    chk("rd_lba", bus.sd_lba, 32'h1234);
    bus.req_lba[HDD*32 +: 32] = 32'hFFFF;
    bus.sd_ack = 1'b1;
    #1;
    chk("rd_req_ack", bus.req_ack, 3'b010);
    tick(1);
    chk("rd_strobe_clr", bus.sd_rd, 1'b0);
    chk("rd_lba_hold", bus.sd_lba, 32'h1234);
    bus.req_rd = 3'b000;
    hits = 0;
    stray = 0;
    for (int i = 0; i < 512; i++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      if (bus.req_buff_wr == 3'b010) hits++;
      if ((bus.req_buff_wr & 3'b101) != 3'b000) stray++;
      tick(1);
      bus.sd_buff_wr = 1'b0;
    end
    chk("rd_strobes", hits, 512);
    chk("rd_stray", stray, 0);
    bus.sd_ack = 1'b0;
    tick(1);
    chk("rd_done_grant", bus.grant, 3'b010);
    tick(1);
    chk("rd_release", bus.grant, 3'b000);
    chk("rd_idle", bus.busy, 1'b0);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) bus.req_lba[i*32 +: 32] = 32'h100 * (i + 1);
    bus.req_rd = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("rr_grant%0d", k), bus.grant, 3'b001 << (k % 3));
      chk($sformatf("rr_lba%0d", k), bus.sd_lba, 32'h100 * ((k % 3) + 1));
      if (k == 3) bus.req_rd = 3'b000;
      bus.sd_ack = 1'b1;
      tick(1);
      bus.sd_ack = 1'b0;
      tick(2);
    end
    chk("rr_idle", bus.busy, 1'b0);

    // Write routing on floppy 2
    bus.req_buff_din = {8'hA5, 8'h22, 8'h11};
    #1;
    chk("wr_din_idle", bus.sd_buff_din, 8'h00);
    bus.req_wr = 3'b100;
    tick(1);
    chk("wr_grant", bus.grant, 3'b100);
    chk("wr_strobe", bus.sd_wr, 1'b1);
    chk("wr_no_rd", bus.sd_rd, 1'b0);
    chk("wr_din", bus.sd_buff_din, 8'hA5);
    bus.sd_ack = 1'b1;
    tick(1);
    bus.req_wr = 3'b000;
    chk("wr_strobe_clr", bus.sd_wr, 1'b0);
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("wr_buff_wr", bus.req_buff_wr, 3'b100);
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack = 1'b0;
    tick(2);
    chk("wr_release", bus.grant, 3'b000);
    chk("wr_din_after", bus.sd_buff_din, 8'h00);

    // Read and write together on floppy 1: read first, write on the next grant
    bus.req_rd = 3'b001;
    bus.req_wr = 3'b001;
    tick(1);
    chk("rw_grant1", bus.grant, 3'b001);
    chk("rw_rd1", bus.sd_rd, 1'b1);
    chk("rw_wr1", bus.sd_wr, 1'b0);
    bus.sd_ack = 1'b1;
    tick(1);
    bus.req_rd = 3'b000;
    bus.sd_ack = 1'b0;
    tick(2);
    chk("rw_gap", bus.grant, 3'b000);
    tick(1);
    chk("rw_grant2", bus.grant, 3'b001);
    chk("rw_rd2", bus.sd_rd, 1'b0);
    chk("rw_wr2", bus.sd_wr, 1'b1);
    bus.sd_ack = 1'b1;
    tick(1);
    bus.req_wr = 3'b000;
    bus.sd_ack = 1'b0;
    tick(2);
    chk("rw_idle", bus.busy, 1'b0);

    // Timeout: no ack for floppy 1
    bus.req_rd = 3'b001;
    tick(1);
    chk("to_grant", bus.grant, 3'b001);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.timeout_err !== 1'b0 || bus.grant !== 3'b001) hits++;
    end
    chk("to_early", hits, 0);
    tick(1);
    chk("to_pulse", bus.timeout_err, 1'b1);
    chk("to_grant_clr", bus.grant, 3'b000);
    chk("to_rd_clr", bus.sd_rd, 1'b0);
    chk("to_busy", bus.busy, 1'b0);
    bus.req_rd = 3'b010;
    tick(1);
    chk("to_single", bus.timeout_err, 1'b0);
    chk("to_next_grant", bus.grant, 3'b010);
    bus.sd_ack = 1'b1;
    tick(1);
    bus.req_rd = 3'b000;
    bus.sd_ack = 1'b0;
    tick(2);

    // Reset in the middle of a transfer, then a stray ack fall
    bus.req_rd = 3'b001;
    tick(1);
    bus.sd_ack = 1'b1;
    tick(1);
    bus.req_rd = 3'b000;
    reset = 1'b1;
    tick(1);
    chk("xr_grant", bus.grant, 3'b000);
    chk("xr_rd", bus.sd_rd, 1'b0);
    chk("xr_lba", bus.sd_lba, 32'h0);
    chk("xr_busy", bus.busy, 1'b0);
    chk("xr_req_ack", bus.req_ack, 3'b000);
    reset = 1'b0;
    tick(1);
    bus.sd_ack = 1'b0;
    tick(2);
    chk("xr_after_busy", bus.busy, 1'b0);
    chk("xr_after_grant", bus.grant, 3'b000);
    bus.sd_ack = 1'b1;
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("idle_buff_wr", bus.req_buff_wr, 3'b000);
    chk("idle_req_ack", bus.req_ack, 3'b000);
    tick(1);
    chk("idle_ack_busy", bus.busy, 1'b0);
    bus.sd_ack = 1'b0;
    bus.sd_buff_wr = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_channel_arbiter.md
Name: sd_channel_arbiter

Overview:
- Shares the single MiSTer block-device channel between floppy_track_1, floppy_track_2 and the HDD sequencer. The channel comprises sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_wr and sd_buff_din.
- Grants one requester at a time using round-robin. Latches the granted LBA and direction, then routes ack, buff_wr and write data to and from the winner.
- Sits in the emu wrapper between the requesters and the host SD interface.

Parameters:
- N_REQ, 3, number of requesters; index 0 = floppy 1, 1 = HDD, 2 = floppy 2.
- LBA_W, 32, LBA width.
- TIMEOUT_CYCLES, 0, maximum cycles in REQ before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock (clk_sys, 14 MHz).
- reset  in  1  synchronous, active-high reset.
- req_lba  in  N_REQ*LBA_W  per-requester LBA, flattened; requester i occupies bits [i*LBA_W +: LBA_W].
- req_rd  in  N_REQ  read request level per requester.
- req_wr  in  N_REQ  write request level per requester.
- req_ack  out  N_REQ  sd_ack & grant[i].
- req_buff_din  in  N_REQ*8  write data from each requester's buffer.
- req_buff_wr  out  N_REQ  sd_buff_wr & sd_ack & grant[i].
- sd_lba  out  LBA_W  LBA to host.
- sd_rd  out  1  read strobe to host.
- sd_wr  out  1  write strobe to host.
- sd_ack  in  1  host acknowledge, high for the whole transfer.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  req_buff_din slice of the granted requester; 0 when nothing is granted.
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values (any cycle, including mid-transfer):
  - state = IDLE, rr_ptr = 0.
  - grant = 0, sd_rd = 0, sd_wr = 0, sd_lba = 0, timeout_err = 0.
  - Timeout counter = 0, ack_d = 0.
  - A host transfer in flight at reset is abandoned; its ack is ignored.
- Pending vector: pend[i] = req_rd[i] | req_wr[i]. Requesters hold their level until req_ack[i] rises.
- States:
  - IDLE: if pend != 0, rr_pick selects the first set bit at or above rr_ptr, wrapping. Next cycle:
    - state = REQ, grant = onehot(w), sd_lba = req_lba[w].
    - sd_rd = req_rd[w]; sd_wr = req_wr[w] & ~req_rd[w]. Read wins over write; the write stays pending and is served on a later grant.
    - rr_ptr = (w+1) mod N_REQ.
  - REQ: ack_d is sd_ack registered. On ~ack_d & sd_ack:
    - state = XFER; sd_rd and sd_wr cleared on the same edge.
    - Timeout: if TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES-1 without an ack rise, clear sd_rd, sd_wr and grant, pulse timeout_err, return to IDLE. rr_ptr is already advanced.
  - XFER: grant held. On ack_d & ~sd_ack, go to DONE.
  - DONE: one cycle. grant still asserted, then cleared; state = IDLE.
- Latency:
  - Request to host strobe: 1 cycle.
  - Ack fall to grant release: 2 cycles.
  - Next grant may start in the cycle following DONE.
- sd_lba is latched at grant and stable until the next grant, even if req_lba changes.
- req_ack, req_buff_wr and sd_buff_din are combinational from grant, so data routing has zero latency.
- sd_ack or sd_buff_wr arriving in IDLE: no effect; all gated outputs are 0.
- Ack already high when REQ is entered: no rising edge is seen, so the arbiter waits. A timeout aborts if enabled.
- A requester dropping its request while granted in REQ: sd_rd/sd_wr are still held until ack or timeout; no early cancel.
- Simultaneous new requests during REQ/XFER/DONE are queued implicitly by their held levels.
- Fairness: with all requesters asserting continuously, grants go 0, 1, 2, 0, ...

Decomposition:
- Package sd_arb_pkg holds:
  - state enum {IDLE, REQ, XFER, DONE};
  - default N_REQ and LBA_W constants;
  - requester index localparams FDD1 = 0, HDD = 1, FDD2 = 2.
- Sub-module rr_pick: combinational round-robin one-hot selector. Inputs pend and rr_ptr; outputs winner index and valid.

Test Plan:
- Single read: req_rd[1] = 1, req_lba[1] = 0x1234.
  - Next cycle: grant = 3'b010, sd_rd = 1, sd_lba = 0x1234.
  - sd_ack rises: sd_rd = 0 next edge.
  - 512 sd_buff_wr strobes: all appear on req_buff_wr[1] only.
  - Ack falls: grant = 0 two cycles later.
- Round-robin: all three req_rd held high across three transfers. Grant order 0, 1, 2; rr_ptr returns to 0.
- Write routing: req_wr[2] = 1, req_buff_din[2] = 0xA5. While granted: sd_wr = 1, sd_buff_din = 0xA5, and sd_buff_din is 0 when idle.
- rd and wr together on index 0: first grant issues sd_rd only. After DONE, sd_wr is issued for index 0 once it wins again; with only index 0 pending, that happens immediately.
- Timeout: TIMEOUT_CYCLES = 16, req_rd[0] = 1, no ack. timeout_err pulses once on the 16th REQ cycle; grant = 0; sd_rd = 0; a subsequent req_rd[1] is granted.
- Reset during XFER: sd_ack held high. All outputs return to 0 the next cycle, and a spurious ack fall after reset causes no state change.
